// File: rtl/tilt_pkg.sv
// Shared types and default tuning constants for the tilt-to-move controller.
package tilt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPos,
    StNeg
  } axis_state_e;

  localparam int          DefDeadZone   = 64;
  localparam int          DefHyst       = 16;
  localparam int unsigned DefRepeatCyc  = 2500000;
  localparam int unsigned DefDebounceCyc = 500000;

endpackage

// File: rtl/tilt_axis.sv
// One accelerometer axis: moving-average filter, IDLE/POS/NEG hysteresis FSM and step pulses.
// Define TILT_AUTOREPEAT_EN to re-pulse every RepeatCyc clocks while an axis stays tilted.
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int unsigned DataW     = 16,
  parameter int unsigned AvgLog2   = 2,
  parameter int          DeadZone  = DefDeadZone,
  parameter int          Hyst      = DefHyst,
  parameter int unsigned RepeatCyc = DefRepeatCyc
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    sample_valid_i,
  input  logic signed [DataW-1:0] sample_i,
  output logic signed [DataW-1:0] filt_o,
  output logic                    filt_valid_o,
  output logic                    pos_o,
  output logic                    neg_o
);

  localparam int unsigned Depth = 1 << AvgLog2;
  localparam int unsigned SumW  = DataW + AvgLog2;
  localparam int unsigned PtrW  = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int          Enter = DeadZone + Hyst;

  logic signed [DataW-1:0] buf_q [Depth];
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic signed [SumW-1:0]  sum_q, sum_d;
  logic signed [DataW-1:0] filt_q, filt_d;
  logic                    filt_valid_q;
  axis_state_e             state_q, state_d;
  logic                    pos_q, pos_d, neg_q, neg_d;

  // Sign-extended add/subtract; SumW leaves room for a full window of extreme samples.
  always_comb begin
    sum_d  = sum_q + SumW'(sample_i) - SumW'(buf_q[ptr_q]);
    filt_d = DataW'(sum_d >>> AvgLog2);
    ptr_d  = (Depth == 1) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) buf_q[i] <= '0;
      ptr_q        <= '0;
      sum_q        <= '0;
      filt_q       <= '0;
      filt_valid_q <= 1'b0;
    end else begin
      filt_valid_q <= sample_valid_i;
      if (sample_valid_i) begin
        buf_q[ptr_q] <= sample_i;
        ptr_q        <= ptr_d;
        sum_q        <= sum_d;
        filt_q       <= filt_d;
      end
    end
  end

`ifdef TILT_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(RepeatCyc + 1);
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (!enable_i) begin
      state_d = StIdle;
    end else if (filt_valid_q) begin
      case (state_q)
        StIdle: begin
          if (filt_q > Enter) begin
            state_d = StPos;
            pos_d   = 1'b1;
          end else if (filt_q < -Enter) begin
            state_d = StNeg;
            neg_d   = 1'b1;
          end
        end
        StPos:   if (filt_q < DeadZone) state_d = StIdle;
        StNeg:   if (filt_q > -DeadZone) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
`ifdef TILT_AUTOREPEAT_EN
    // Counter restarts on any state change so the first repeat lands RepeatCyc after entry.
    rep_cnt_d = '0;
    if (state_d == state_q && state_q != StIdle) begin
      if (rep_cnt_q == RepW'(RepeatCyc - 1)) begin
        pos_d = (state_q == StPos);
        neg_d = (state_q == StNeg);
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

`ifdef TILT_AUTOREPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rep_cnt_q <= '0;
    else         rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign filt_o       = filt_q;
  assign filt_valid_o = filt_valid_q;
  assign pos_o        = pos_q;
  assign neg_o        = neg_q;

endmodule

// File: rtl/tilt_move_ctrl.sv
// Tilt-to-move controller: per-axis filtered step pulses plus a debounced fire button.
// Define TILT_AUTOREPEAT_EN to enable auto-repeat of step pulses while tilted.
module tilt_move_ctrl
  import tilt_pkg::*;
#(
  parameter int unsigned NUM_AXES     = 2,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int          DEAD_ZONE    = DefDeadZone,
  parameter int          HYST         = DefHyst,
  parameter int unsigned REPEAT_CYC   = DefRepeatCyc,
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc
) (
  input  logic                       iCLK,
  input  logic                       iRSTN,
  input  logic                       iSAMPLE_VALID,
  input  logic [NUM_AXES*DATA_W-1:0] iSAMPLE_DATA,
  input  logic                       iENABLE,
  input  logic                       iFIRE_N,
  output logic [NUM_AXES-1:0]        oPOS,
  output logic [NUM_AXES-1:0]        oNEG,
  output logic                       oFIRE,
  output logic [NUM_AXES*DATA_W-1:0] oFILT,
  output logic                       oFILT_VALID
);

  logic [NUM_AXES-1:0] filt_valid;

  for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
    tilt_axis #(
      .DataW    (DATA_W),
      .AvgLog2  (AVG_LOG2),
      .DeadZone (DEAD_ZONE),
      .Hyst     (HYST),
      .RepeatCyc(REPEAT_CYC)
    ) u_axis (
      .clk_i         (iCLK),
      .rst_ni        (iRSTN),
      .enable_i      (iENABLE),
      .sample_valid_i(iSAMPLE_VALID),
      .sample_i      (iSAMPLE_DATA[k*DATA_W +: DATA_W]),
      .filt_o        (oFILT[k*DATA_W +: DATA_W]),
      .filt_valid_o  (filt_valid[k]),
      .pos_o         (oPOS[k]),
      .neg_o         (oNEG[k])
    );
  end

  // All axes share the same strobe, so any lane represents the update.
  assign oFILT_VALID = filt_valid[0];

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]     fire_sync_q;
  logic           fire_stable_q, fire_stable_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           fire_q, fire_d;

  // A change is accepted only after DEBOUNCE_CYC consecutive cycles at the new level.
  always_comb begin
    fire_stable_d = fire_stable_q;
    db_cnt_d      = '0;
    fire_d        = 1'b0;
    if (fire_sync_q[1] != fire_stable_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
        fire_stable_d = fire_sync_q[1];
        fire_d        = ~fire_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      fire_sync_q   <= 2'b11;
      fire_stable_q <= 1'b1;
      db_cnt_q      <= '0;
      fire_q        <= 1'b0;
    end else begin
      fire_sync_q   <= {fire_sync_q[0], iFIRE_N};
      fire_stable_q <= fire_stable_d;
      db_cnt_q      <= db_cnt_d;
      fire_q        <= fire_d;
    end
  end

  assign oFIRE = fire_q;

endmodule

// File: tb/tb_tilt_move_ctrl.sv
// Scoreboard bench for tilt_move_ctrl: a reference model queues expected filter/pulse results.
module tb_tilt_move_ctrl;

  localparam int NA = 2;
  localparam int DW = 16;
  localparam int RepCyc = 10;
`ifdef TILT_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic             iCLK = 1'b0;
  logic             iRSTN;
  logic             iSAMPLE_VALID;
  logic [NA*DW-1:0] iSAMPLE_DATA;
  logic             iENABLE;
  logic             iFIRE_N;
  logic [NA-1:0]    oPOS, oNEG;
  logic             oFIRE;
  logic [NA*DW-1:0] oFILT;
  logic             oFILT_VALID;

  tilt_move_ctrl #(
    .NUM_AXES    (NA),
    .DATA_W      (DW),
    .AVG_LOG2    (2),
    .DEAD_ZONE   (64),
    .HYST        (16),
    .REPEAT_CYC  (RepCyc),
    .DEBOUNCE_CYC(8)
  ) dut (
    .iCLK         (iCLK),
    .iRSTN        (iRSTN),
    .iSAMPLE_VALID(iSAMPLE_VALID),
    .iSAMPLE_DATA (iSAMPLE_DATA),
    .iENABLE      (iENABLE),
    .iFIRE_N      (iFIRE_N),
    .oPOS         (oPOS),
    .oNEG         (oNEG),
    .oFIRE        (oFIRE),
    .oFILT        (oFILT),
    .oFILT_VALID  (oFILT_VALID)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int       f0;
    int       f1;
    bit [1:0] pos;
    bit [1:0] neg;
    bit [1:0] care;
    int       cyc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  int        mbuf[NA][4];
  int        msum[NA];
  int        mstate[NA];
  int        mptr;
  bit        pend;
  sb_entry_t pend_e;
  int        pos_cnt[NA];
  int        neg_cnt[NA];
  int        fire_cnt;
  int        pos0_cyc[$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin
      for (int i = 0; i < 4; i++) mbuf[k][i] = 0;
      msum[k]   = 0;
      mstate[k] = 0;
    end
    mptr = 0;
    sb.delete();
    pend = 1'b0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NA; k++) begin
      pos_cnt[k] = 0;
      neg_cnt[k] = 0;
    end
    fire_cnt = 0;
    pos0_cyc.delete();
  endtask

  // Reference: 4-sample floor average, then 0=idle/1=pos/2=neg with enter 80, leave 64.
  task automatic push_sample(input int s0, input int s1);
    sb_entry_t e;
    int s[NA];
    int f;
    s[0] = s0;
    s[1] = s1;
    e.pos = '0;
    e.neg = '0;
    e.care = '1;
    for (int k = 0; k < NA; k++) begin
      msum[k] = msum[k] + s[k] - mbuf[k][mptr];
      mbuf[k][mptr] = s[k];
      f = msum[k] >>> 2;
      if (k == 0) e.f0 = f;
      else        e.f1 = f;
      if (!iENABLE) mstate[k] = 0;
      else begin
        case (mstate[k])
          0: begin
            if (f > 80) begin
              mstate[k] = 1;
              e.pos[k] = 1'b1;
            end else if (f < -80) begin
              mstate[k] = 2;
              e.neg[k] = 1'b1;
            end
          end
          1: if (f < 64) mstate[k] = 0; else e.care[k] = !AutoRep;
          default: if (f > -64) mstate[k] = 0; else e.care[k] = !AutoRep;
        endcase
      end
    end
    mptr = (mptr + 1) % 4;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drive_sample(input int s0, input int s1, input int gap);
    @(posedge iCLK);
    #1;
    iSAMPLE_DATA  = {DW'(s1), DW'(s0)};
    iSAMPLE_VALID = 1'b1;
    push_sample(s0, s1);
    @(posedge iCLK);
    #1;
    iSAMPLE_VALID = 1'b0;
    repeat (gap) @(posedge iCLK);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_pos"}, oPOS, 0);
    check({tag, "_neg"}, oNEG, 0);
    check({tag, "_fire"}, oFIRE, 0);
    check({tag, "_filt"}, oFILT, 0);
    check({tag, "_fvalid"}, oFILT_VALID, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge iCLK);
    #1;
    iRSTN = 1'b0;
    model_reset();
    repeat (2) @(posedge iCLK);
    #1;
    check_outputs_idle(tag);
    iRSTN = 1'b1;
  endtask

  task automatic set_fire(input logic val, input int n);
    iFIRE_N = val;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (iRSTN === 1'b1) begin
      if (oFILT_VALID) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_update", 1, 0);
        end else begin
          pend_e = sb.pop_front();
          check("filt0", $signed(oFILT[DW-1:0]), pend_e.f0);
          check("filt1", $signed(oFILT[2*DW-1:DW]), pend_e.f1);
          check("filt_latency", cyc - pend_e.cyc, 1);
          pend = 1'b1;
        end
      end else if (pend) begin
        pend = 1'b0;
        check("step_pos", oPOS & pend_e.care, pend_e.pos & pend_e.care);
        check("step_neg", oNEG & pend_e.care, pend_e.neg & pend_e.care);
      end
      if ((oPOS | oNEG) != 0) check("pos_neg_overlap", oPOS & oNEG, 0);
      for (int k = 0; k < NA; k++) begin
        if (oPOS[k]) pos_cnt[k]++;
        if (oNEG[k]) neg_cnt[k]++;
      end
      if (oPOS[0]) pos0_cyc.push_back(cyc);
      if (oFIRE) fire_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_rep;
    iRSTN         = 1'b0;
    iSAMPLE_VALID = 1'b0;
    iSAMPLE_DATA  = '0;
    iENABLE       = 1'b1;
    iFIRE_N       = 1'b1;
    model_reset();
    clear_counts();
    repeat (3) @(posedge iCLK);
    #1;
    check_outputs_idle("reset");
    iRSTN = 1'b1;

    // Warm-up: 400s average in as 100,200,300,400; entry on the 100 update.
    for (int i = 0; i < 4; i++) drive_sample(400, 0, 3);
    repeat (2) @(posedge iCLK);

    // Hysteresis: settle at 70, rise to 90, fall to 70 then 60.
    do_reset("rst_hyst");
    for (int i = 0; i < 4; i++) drive_sample(70, 0, 3);
    for (int i = 0; i < 4; i++) drive_sample(90, 0, 3);
    for (int i = 0; i < 4; i++) drive_sample(70, 0, 3);
    for (int i = 0; i < 4; i++) drive_sample(60, 0, 3);
    repeat (2) @(posedge iCLK);

    // Auto-repeat: a single 400 sample enters POS and holds there.
    do_reset("rst_rep");
    clear_counts();
    drive_sample(400, 0, 0);
    repeat (36) @(posedge iCLK);
    #1;
    exp_rep = AutoRep ? 4 : 1;
    check("repeat_count", pos0_cyc.size(), exp_rep);
    for (int i = 1; i < pos0_cyc.size() && i < exp_rep; i++)
      check("repeat_offset", pos0_cyc[i] - pos0_cyc[0], i * RepCyc);

    // Reversal: axis0 +400 -> -400, axis1 the opposite way.
    do_reset("rst_rev");
    for (int i = 0; i < 4; i++) drive_sample(400, -400, 3);
    clear_counts();
    for (int i = 0; i < 4; i++) drive_sample(-400, 400, 3);
    repeat (2) @(posedge iCLK);
    #1;
    check("rev_neg0_count", neg_cnt[0], 1);
    check("rev_pos1_count", pos_cnt[1], 1);

    // Enable low: filter runs, no steps; re-enable steps on the next update.
    do_reset("rst_en");
    iENABLE = 1'b0;
    clear_counts();
    for (int i = 0; i < 4; i++) drive_sample(400, 400, 3);
    repeat (2) @(posedge iCLK);
    #1;
    check("dis_pos0_count", pos_cnt[0], 0);
    check("dis_pos1_count", pos_cnt[1], 0);
    iENABLE = 1'b1;
    drive_sample(400, 400, 3);

    // Reset while an entry pulse is pending, then reset while holding POS.
    do_reset("rst_mid");
    @(posedge iCLK);
    #1;
    iSAMPLE_DATA  = {DW'(0), DW'(400)};
    iSAMPLE_VALID = 1'b1;
    @(posedge iCLK);
    #1;
    iSAMPLE_VALID = 1'b0;
    iRSTN = 1'b0;
    model_reset();
    repeat (2) @(posedge iCLK);
    #1;
    check_outputs_idle("rst_pending");
    iRSTN = 1'b1;
    clear_counts();
    repeat (15) @(posedge iCLK);
    #1;
    check("after_rst_pos0", pos_cnt[0], 0);
    drive_sample(400, 0, 3);
    do_reset("rst_in_pos");
    clear_counts();
    repeat (15) @(posedge iCLK);
    #1;
    check("after_rst2_pos0", pos_cnt[0], 0);
    check("after_rst2_neg0", neg_cnt[0], 0);
    drive_sample(400, 0, 3);
    repeat (2) @(posedge iCLK);

    // Fire button: bouncy press, release, then a short glitch; enable is off.
    iENABLE = 1'b0;
    clear_counts();
    set_fire(1'b0, 3);
    set_fire(1'b1, 3);
    set_fire(1'b0, 3);
    set_fire(1'b1, 3);
    set_fire(1'b0, 20);
    check("fire_press", fire_cnt, 1);
    set_fire(1'b1, 20);
    check("fire_release", fire_cnt, 1);
    set_fire(1'b0, 5);
    set_fire(1'b1, 20);
    check("fire_glitch", fire_cnt, 1);

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tilt_move_ctrl.md
TILT_MOVE_CTRL -- requirements
Module: tilt_move_ctrl

Interface
REQ-001 SHALL have parameter NUM_AXES, default 2: number of accelerometer axes handled (1..3).
REQ-002 SHALL have parameter DATA_W, default 16: signed two's-complement sample width per axis.
REQ-003 SHALL have parameter AVG_LOG2, default 2: moving-average window of 2^AVG_LOG2 samples (0..4).
REQ-004 SHALL have parameter DEAD_ZONE, default 64: magnitude threshold for leaving a move state.
REQ-005 SHALL have parameter HYST, default 16: extra magnitude needed to enter a move state.
REQ-006 SHALL have parameter REPEAT_CYC, default 2500000: auto-repeat period, in clocks.
REQ-007 SHALL have parameter DEBOUNCE_CYC, default 500000: fire-button stable time, in clocks.
REQ-008 SHALL have port iCLK, input, 1 bit: single clock; all logic is in this domain.
REQ-009 SHALL have port iRSTN, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port iSAMPLE_VALID, input, 1 bit: one-cycle strobe qualifying iSAMPLE_DATA.
REQ-011 SHALL have port iSAMPLE_DATA, input, NUM_AXES*DATA_W bits: axis k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port iENABLE, input, 1 bit: when 0, moves are suppressed.
REQ-013 SHALL have port iFIRE_N, input, 1 bit: raw, asynchronous, active-low key.
REQ-014 SHALL have port oPOS, output, NUM_AXES bits: one-cycle positive-step pulse per axis.
REQ-015 SHALL have port oNEG, output, NUM_AXES bits: one-cycle negative-step pulse per axis.
REQ-016 SHALL have port oFIRE, output, 1 bit: one-cycle pulse per debounced press.
REQ-017 SHALL have port oFILT, output, NUM_AXES*DATA_W bits: filtered value per axis.
REQ-018 SHALL have port oFILT_VALID, output, 1 bit: strobe marking an oFILT update.

Function
REQ-019 SHALL keep, per axis, a circular buffer of 2^AVG_LOG2 samples and a running sum of width DATA_W+AVG_LOG2 that never overflows.
REQ-020 SHALL, on each iSAMPLE_VALID: sum += new − oldest; overwrite the oldest slot; advance the write pointer modulo 2^AVG_LOG2.
REQ-021 SHALL set oFILT = sum >>> AVG_LOG2 (arithmetic shift, floor) and pulse oFILT_VALID exactly 1 cycle after iSAMPLE_VALID.
REQ-022 SHALL include reset-cleared zero entries in the average during warm-up, with no special case.
REQ-023 SHALL run a per-axis FSM with states IDLE, POS, NEG, evaluated only on the oFILT_VALID cycle.
REQ-024 SHALL take FSM transitions as follows:
- IDLE→POS when filt > DEAD_ZONE+HYST.
- IDLE→NEG when filt < −(DEAD_ZONE+HYST).
- POS→IDLE when filt < DEAD_ZONE.
- NEG→IDLE when filt > −DEAD_ZONE.
- No direct POS↔NEG transition; a full reversal takes ≥2 updates.
REQ-025 SHALL pulse oPOS/oNEG for that axis on the cycle after entry into POS/NEG.
REQ-026 SHALL never assert oPOS[k] and oNEG[k] together.
REQ-027 SHALL, while iENABLE=0, force every FSM to IDLE and hold oPOS/oNEG at 0; the filter keeps running.
REQ-028 SHALL pass iFIRE_N through a 2-FF synchroniser, then require the level to be stable DEBOUNCE_CYC cycles before accepting a change.
REQ-029 SHALL pulse oFIRE once on each accepted high→low transition, independent of iENABLE.

Reset
REQ-030 SHALL, with iRSTN low, clear all of the following: buffers, sums, pointers, oFILT, oFILT_VALID, oPOS, oNEG, oFIRE, repeat and debounce counters.
REQ-031 SHALL hold every FSM in IDLE and preset the debounced button state to released (1) during reset.
REQ-032 SHALL, on reset asserted mid-operation, abort any pending pulse; nothing is emitted after release until new qualifying input.

Configuration
REQ-033 SHALL, with TILT_AUTOREPEAT_EN defined, re-pulse oPOS/oNEG every REPEAT_CYC cycles while the axis stays in POS/NEG.
REQ-034 SHALL restart the repeat counter on each state entry.
REQ-035 SHALL, without TILT_AUTOREPEAT_EN, emit only the entry pulse and compile out the repeat counters.

Structure
REQ-036 SHALL place in shared package tilt_pkg:
- the axis-state enum (IDLE/POS/NEG);
- default constants for DEAD_ZONE, HYST, REPEAT_CYC, DEBOUNCE_CYC.
REQ-037 SHALL implement filter, FSM and repeat logic for one axis in sub-module tilt_axis, generated NUM_AXES times.
REQ-038 SHALL keep the fire debouncer in the top level.

Verification (DATA_W=16, AVG_LOG2=2, DEAD_ZONE=64, HYST=16, REPEAT_CYC=10, DEBOUNCE_CYC=8)
REQ-039 SHALL cover filter warm-up: axis0 samples 400,400,400,400 → oFILT0 = 100,200,300,400, each 1 cycle after its strobe; single oPOS[0] pulse on the update where filt first exceeds 80 (the 100 update).
REQ-040 SHALL cover hysteresis: settled filt=70 from IDLE → no pulse; filt=90 → oPOS pulse; filt=70 → stays POS; filt=60 → IDLE with no pulse.
REQ-041 SHALL cover auto-repeat (macro on): hold POS for 35 cycles → pulses at entry+0, +10, +20, +30; macro off → entry pulse only.
REQ-042 SHALL cover reversal: step samples from +400 to −400 → at least one update in IDLE before NEG; oNEG fires once; no oPOS/oNEG overlap.
REQ-043 SHALL cover fire: iFIRE_N low with 3-cycle bounces, then low for 20 cycles → exactly one oFIRE; a 5-cycle glitch → no oFIRE.
REQ-044 SHALL cover reset and enable: iRSTN pulsed low while in POS → all outputs 0, FSM IDLE after release; iENABLE=0 with filt=400 → no pulses, oFILT still updates.
